// File: rtl/univ_reg_n.sv
// Multi-mode WIDTH-bit register: parallel load, shift/rotate both ways,
// up/down count with a registered one-cycle wrap flag, synchronous clear.
module univ_reg_n #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             wrap
);

  typedef enum logic [2:0] {
    MODE_HOLD = 3'b000,
    MODE_LOAD = 3'b001,
    MODE_SHL  = 3'b010,
    MODE_SHR  = 3'b011,
    MODE_ROL  = 3'b100,
    MODE_ROR  = 3'b101,
    MODE_UP   = 3'b110,
    MODE_DOWN = 3'b111
  } mode_t;

  localparam logic [WIDTH-1:0] ONES = '1;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  logic [WIDTH-1:0] q_nxt;
  logic             sout_nxt;
  logic             wrap_nxt;

  // wrap defaults to 0 so it can only ever be a single-cycle pulse
  always_comb begin
    q_nxt    = q;
    sout_nxt = sout;
    wrap_nxt = 1'b0;
    if (clr) begin
      q_nxt    = RST_VAL;
      sout_nxt = 1'b0;
    end else if (en) begin
      case (mode_t'(mode))
        MODE_HOLD: q_nxt = q;
        MODE_LOAD: q_nxt = d;
        MODE_SHL: begin
          q_nxt    = {q[WIDTH-2:0], sin};
          sout_nxt = q[WIDTH-1];
        end
        MODE_SHR: begin
          q_nxt    = {sin, q[WIDTH-1:1]};
          sout_nxt = q[0];
        end
        MODE_ROL: begin
          q_nxt    = {q[WIDTH-2:0], q[WIDTH-1]};
          sout_nxt = q[WIDTH-1];
        end
        MODE_ROR: begin
          q_nxt    = {q[0], q[WIDTH-1:1]};
          sout_nxt = q[0];
        end
        MODE_UP: begin
          q_nxt    = q + ONE;
          wrap_nxt = (q == ONES);
        end
        MODE_DOWN: begin
          q_nxt    = q - ONE;
          wrap_nxt = (q == '0);
        end
        default: q_nxt = q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q    <= RST_VAL;
      sout <= 1'b0;
      wrap <= 1'b0;
    end else begin
      q    <= q_nxt;
      sout <= sout_nxt;
      wrap <= wrap_nxt;
    end
  end

endmodule

// File: tb/tb_univ_reg_n.sv
// Bench for univ_reg_n: a behavioural model pushes {q,sout,wrap} into an
// expected queue per driven edge; the value is popped and compared after the edge.
module tb_univ_reg_n;

  localparam int               WIDTH   = 8;
  localparam logic [WIDTH-1:0] RST_VAL = 8'hA5;
  localparam int               W       = WIDTH + 2;

  logic             clk;
  logic             reset;
  logic             clr;
  logic             en;
  logic [2:0]       mode;
  logic [WIDTH-1:0] d;
  logic             sin;
  logic [WIDTH-1:0] q;
  logic             sout;
  logic             wrap;

  int tests_run = 0;
  int tests_failed = 0;

  logic [W-1:0] exp_q[$];

  logic [WIDTH-1:0] m_q;
  logic             m_sout;
  logic             m_wrap;

  univ_reg_n #(.WIDTH(WIDTH), .RST_VAL(RST_VAL)) dut (
    .clk(clk), .reset(reset), .clr(clr), .en(en), .mode(mode),
    .d(d), .sin(sin), .q(q), .sout(sout), .wrap(wrap)
  );

  // clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got running, need finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    m_q    = RST_VAL;
    m_sout = 1'b0;
    m_wrap = 1'b0;
  endfunction

  // Reference behaviour for one rising edge with reset released.
  function automatic void model_edge(input logic e, input logic c, input logic [2:0] m,
                                     input logic [WIDTH-1:0] dd, input logic s);
    logic [WIDTH-1:0] old;
    old    = m_q;
    m_wrap = 1'b0;
    if (c) begin
      model_reset();
    end else if (e) begin
      unique case (m)
        3'd0: ;
        3'd1: m_q = dd;
        3'd2: begin m_q = (old << 1) | WIDTH'(s); m_sout = old[WIDTH-1]; end
        3'd3: begin m_q = (old >> 1) | ({s, {(WIDTH-1){1'b0}}}); m_sout = old[0]; end
        3'd4: begin m_q = (old << 1) | WIDTH'(old[WIDTH-1]); m_sout = old[WIDTH-1]; end
        3'd5: begin m_q = (old >> 1) | ({old[0], {(WIDTH-1){1'b0}}}); m_sout = old[0]; end
        3'd6: begin m_q = old + 8'd1; m_wrap = (old == 8'hFF); end
        default: begin m_q = old - 8'd1; m_wrap = (old == 8'h00); end
      endcase
    end
  endfunction

  // driver: apply inputs, predict, take one edge, compare after it
  task automatic step(input string tag, input logic e, input logic c, input logic [2:0] m,
                      input logic [WIDTH-1:0] dd, input logic s);
    en = e; clr = c; mode = m; d = dd; sin = s;
    model_edge(e, c, m, dd, s);
    exp_q.push_back({m_q, m_sout, m_wrap});
    @(posedge clk);
    #1;
    check(tag, {q, sout, wrap}, exp_q.pop_front());
  endtask

  task automatic async_reset_pulse(input int low_ns);
    reset = 1'b0;
    model_reset();
    #1;
    check("rst_async", {q, sout, wrap}, {RST_VAL, 2'b00});
    #(low_ns - 1);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b1; clr = 1'b0; en = 1'b0; mode = 3'd0; d = '0; sin = 1'b0;
    m_q = '0; m_sout = 1'b0; m_wrap = 1'b0;

    // reset between edges (edges at 5, 15, ...)
    #7;
    async_reset_pulse(2);
    check("rst_q", 32'(q), 32'(8'hA5));

    // synchronous clear beats enable/load
    step("ld55", 1, 0, 3'd1, 8'h55, 0);
    step("clr", 1, 1, 3'd1, 8'h3C, 0);
    check("clr_q", 32'(q), 32'(8'hA5));

    // load then enable gating
    step("ld3c", 1, 0, 3'd1, 8'h3C, 0);
    for (int i = 0; i < 3; i++) begin
      step("en0", 0, 0, 3'd1, 8'hFF, 1);
      check("en0_q", 32'(q), 32'(8'h3C));
    end

    // shifts
    step("ld81", 1, 0, 3'd1, 8'h81, 0);
    step("shl", 1, 0, 3'd2, 8'h00, 0);
    check("shl_qs", 32'({q, sout}), 32'({8'h02, 1'b1}));
    step("ld81", 1, 0, 3'd1, 8'h81, 0);
    step("shr", 1, 0, 3'd3, 8'h00, 1);
    check("shr_qs", 32'({q, sout}), 32'({8'hC0, 1'b1}));

    // rotates
    step("ld81", 1, 0, 3'd1, 8'h81, 0);
    for (int i = 0; i < 8; i++) step("rol", 1, 0, 3'd4, 8'h00, 1);
    check("rol8_q", 32'(q), 32'(8'h81));
    step("ror", 1, 0, 3'd5, 8'h00, 0);
    check("ror_q", 32'(q), 32'(8'hC0));

    // count up across wrap
    step("ldfe", 1, 0, 3'd1, 8'hFE, 0);
    step("up1", 1, 0, 3'd6, 8'h00, 0);
    check("up1_qw", 32'({q, wrap}), 32'({8'hFF, 1'b0}));
    step("up2", 1, 0, 3'd6, 8'h00, 0);
    check("up2_qw", 32'({q, wrap}), 32'({8'h00, 1'b1}));
    step("up3", 1, 0, 3'd6, 8'h00, 0);
    check("up3_qw", 32'({q, wrap}), 32'({8'h01, 1'b0}));

    // count down across wrap
    step("ld01", 1, 0, 3'd1, 8'h01, 0);
    step("dn1", 1, 0, 3'd7, 8'h00, 0);
    check("dn1_qw", 32'({q, wrap}), 32'({8'h00, 1'b0}));
    step("dn2", 1, 0, 3'd7, 8'h00, 0);
    check("dn2_qw", 32'({q, wrap}), 32'({8'hFF, 1'b1}));
    step("dn3", 1, 0, 3'd7, 8'h00, 0);
    check("dn3_qw", 32'({q, wrap}), 32'({8'hFE, 1'b0}));

    // reset mid-count, then resume from RST_VAL
    step("ld10", 1, 0, 3'd1, 8'h10, 0);
    step("cnt", 1, 0, 3'd6, 8'h00, 0);
    #2;
    async_reset_pulse(5);
    step("resume", 1, 0, 3'd6, 8'h00, 0);
    check("resume_qw", 32'({q, wrap}), 32'({8'hA6, 1'b0}));

    // random traffic against the model
    for (int i = 0; i < 60; i++) begin
      step("rand", 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 9) == 0),
           3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    end

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
